// File: rtl/display_timing.sv
// Pixel-domain display timing generator: free-running frame position with sync,
// data-enable, line/frame strobes and a frame counter, all registered and aligned.
module display_timing #(
   parameter int   CORDW  = 16,
   parameter int   H_RES  = 640,
   parameter int   H_FP   = 16,
   parameter int   H_SYNC = 96,
   parameter int   H_BP   = 48,
   parameter int   V_RES  = 480,
   parameter int   V_FP   = 10,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 33,
   parameter logic H_POL  = 1'b0,
   parameter logic V_POL  = 1'b0,
   parameter int   FCW    = 8
) (
   input  logic             clk_pix,
   input  logic             rst_pix_n,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             line,
   output logic             frame,
   output logic [FCW-1:0]   frame_cnt
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
   localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
   localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
   localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
   localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
   localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
   localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

   if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
      $error("display_timing: sync width must be at least 1");
   end
   if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_porch
      $error("display_timing: porch widths must be non-negative");
   end
   if (H_TOTAL - 1 >= (1 << (CORDW - 1)) || V_TOTAL - 1 >= (1 << (CORDW - 1))) begin : g_bad_width
      $error("display_timing: frame totals overflow CORDW-1 bits");
   end

   // Position held at the last pixel in reset so the first edge lands on (0,0).
   logic [CORDW-1:0] h_pos, v_pos;
   logic [CORDW-1:0] h_nxt, v_nxt;

   always_comb begin
      h_nxt = h_pos + CORDW'(1);
      v_nxt = v_pos;
      if (h_pos == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v_pos == V_LAST) ? '0 : v_pos + CORDW'(1);
      end
   end

   // Every output is decoded from the next position, so all of them share one register stage.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         h_pos     <= H_LAST;
         v_pos     <= V_LAST;
         sx        <= '0;
         sy        <= '0;
         hsync     <= ~H_POL;
         vsync     <= ~V_POL;
         de        <= 1'b0;
         line      <= 1'b0;
         frame     <= 1'b0;
         frame_cnt <= '0;
      end else begin
         h_pos <= h_nxt;
         v_pos <= v_nxt;
         sx    <= h_nxt;
         sy    <= v_nxt;
         hsync <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? H_POL : ~H_POL;
         vsync <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? V_POL : ~V_POL;
         de    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
         line  <= (h_nxt == '0);
         frame <= (h_nxt == '0) && (v_nxt == V_ACT);
         if (h_nxt == '0 && v_nxt == V_ACT) begin
            frame_cnt <= frame_cnt + FCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: default 640x480 timing, a medium config for frame-level
// behaviour and a tiny active-high config checked every cycle against an arithmetic model.
module tb_display_timing;

   typedef struct {
      int hres, hfp, hsw, hbp, vres, vfp, vsw, vbp;
      bit hpol, vpol;
   } cfg_t;

   cfg_t cd, cm, cs;
   int   errors = 0;
   int   checks = 0;

   logic clk = 1'b0;
   logic rst_d, rst_m, rst_s;
   int   n_d, n_m, n_s;

   logic [15:0] sx_d, sy_d, sx_m, sy_m, sx_s, sy_s;
   logic        hs_d, vs_d, de_d, line_d, frame_d;
   logic        hs_m, vs_m, de_m, line_m, frame_m;
   logic        hs_s, vs_s, de_s, line_s, frame_s;
   logic [7:0]  fc_d, fc_m, fc_s;
   logic [44:0] got_d, got_m, got_s;

   assign got_d = {sx_d, sy_d, hs_d, vs_d, de_d, line_d, frame_d, fc_d};
   assign got_m = {sx_m, sy_m, hs_m, vs_m, de_m, line_m, frame_m, fc_m};
   assign got_s = {sx_s, sy_s, hs_s, vs_s, de_s, line_s, frame_s, fc_s};

   always #5 clk = ~clk;

   display_timing dut_d (
      .clk_pix(clk), .rst_pix_n(rst_d), .sx(sx_d), .sy(sy_d), .hsync(hs_d), .vsync(vs_d),
      .de(de_d), .line(line_d), .frame(frame_d), .frame_cnt(fc_d));

   display_timing #(.H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_RES(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_m (
      .clk_pix(clk), .rst_pix_n(rst_m), .sx(sx_m), .sy(sy_m), .hsync(hs_m), .vsync(vs_m),
      .de(de_m), .line(line_m), .frame(frame_m), .frame_cnt(fc_m));

   display_timing #(.H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                    .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .H_POL(1'b1), .V_POL(1'b1)) dut_s (
      .clk_pix(clk), .rst_pix_n(rst_s), .sx(sx_s), .sy(sy_s), .hsync(hs_s), .vsync(vs_s),
      .de(de_s), .line(line_s), .frame(frame_s), .frame_cnt(fc_s));

   // Edges seen since reset release; the model derives everything from this count.
   always @(posedge clk or negedge rst_d) if (!rst_d) n_d <= 0; else n_d <= n_d + 1;
   always @(posedge clk or negedge rst_m) if (!rst_m) n_m <= 0; else n_m <= n_m + 1;
   always @(posedge clk or negedge rst_s) if (!rst_s) n_s <= 0; else n_s <= n_s + 1;

   function automatic logic [44:0] model(input cfg_t c, input int n);
      int ht, vt, ft, p, x, y, f, fc;
      logic hs, vs, de, ln, fr;
      if (n == 0) return {16'd0, 16'd0, ~c.hpol, ~c.vpol, 1'b0, 1'b0, 1'b0, 8'd0};
      ht = c.hres + c.hfp + c.hsw + c.hbp;
      vt = c.vres + c.vfp + c.vsw + c.vbp;
      ft = ht * vt;
      p  = (n - 1) % ft;
      x  = p % ht;
      y  = p / ht;
      f  = c.vres * ht;
      hs = (x >= c.hres + c.hfp && x < c.hres + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
      vs = (y >= c.vres + c.vfp && y < c.vres + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
      de = (x < c.hres) && (y < c.vres);
      ln = (x == 0);
      fr = (x == 0) && (y == c.vres);
      fc = ((n - 1) >= f) ? (((n - 1 - f) / ft) + 1) % 256 : 0;
      return {x[15:0], y[15:0], hs, vs, de, ln, fr, fc[7:0]};
   endfunction

   task automatic do_reset(input int which);
      @(negedge clk);
      case (which)
         0: rst_d = 1'b0;
         1: rst_m = 1'b0;
         default: rst_s = 1'b0;
      endcase
      repeat (3) @(negedge clk);
      case (which)
         0: rst_d = 1'b1;
         1: rst_m = 1'b1;
         default: rst_s = 1'b1;
      endcase
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_d = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (got_d !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_hold actual=%h required=%h", got_d,
                  {16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
      end
      rst_d = 1'b1;
      @(negedge clk);
      checks++;
      if (got_d !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL first_edge actual=%h required=%h", got_d,
                  {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
      end
      @(negedge clk);
      checks++;
      if (sx_d !== 16'd1 || line_d !== 1'b0) begin
         errors++;
         $display("FAIL second_edge actual sx=%0d line=%b required sx=1 line=0", sx_d, line_d);
      end
   endtask

   task automatic test_line_timing;
      int de_cnt = 0, hs_cnt = 0, ln_cnt = 0, max_sx = 0, last_ln = 0;
      do_reset(0);
      for (int i = 0; i < 2400; i++) begin
         @(negedge clk);
         checks++;
         if (got_d !== model(cd, n_d)) begin
            errors++;
            $display("FAIL line_model n=%0d actual=%h required=%h", n_d, got_d, model(cd, n_d));
         end
         if (de_d) de_cnt++;
         if (!hs_d) hs_cnt++;
         if (int'(sx_d) > max_sx) max_sx = int'(sx_d);
         if (line_d) begin
            ln_cnt++;
            if (last_ln > 0) begin
               checks++;
               if (n_d - last_ln != 800) begin
                  errors++;
                  $display("FAIL line_period actual=%0d required=800", n_d - last_ln);
               end
            end
            last_ln = n_d;
         end
      end
      checks++;
      if (de_cnt != 1920) begin
         errors++;
         $display("FAIL de_count actual=%0d required=1920", de_cnt);
      end
      checks++;
      if (hs_cnt != 288) begin
         errors++;
         $display("FAIL hsync_count actual=%0d required=288", hs_cnt);
      end
      checks++;
      if (ln_cnt != 3) begin
         errors++;
         $display("FAIL line_count actual=%0d required=3", ln_cnt);
      end
      checks++;
      if (max_sx != 799) begin
         errors++;
         $display("FAIL max_sx actual=%0d required=799", max_sx);
      end
   endtask

   task automatic test_frame_timing;
      int nfr = 0, lines = 0, vs_cnt = 0, de_bad = 0, wraps = 0;
      int prev_sy = 0;
      do_reset(1);
      for (int i = 0; i < 2 * 437 + 23; i++) begin
         @(negedge clk);
         checks++;
         if (got_m !== model(cm, n_m)) begin
            errors++;
            $display("FAIL frame_model n=%0d actual=%h required=%h", n_m, got_m, model(cm, n_m));
         end
         if (n_m <= 874 && !vs_m) vs_cnt++;
         if (de_m && sy_m >= 16'd12) de_bad++;
         if (prev_sy == 18 && sy_m == 16'd0) wraps++;
         prev_sy = int'(sy_m);
         if (nfr == 1 && line_m) lines++;
         if (frame_m) begin
            nfr++;
            checks++;
            if (sx_m !== 16'd0 || sy_m !== 16'd12) begin
               errors++;
               $display("FAIL frame_pos actual=(%0d,%0d) required=(0,12)", sx_m, sy_m);
            end
         end
      end
      checks++;
      if (nfr != 2) begin
         errors++;
         $display("FAIL frame_strobes actual=%0d required=2", nfr);
      end
      checks++;
      if (lines != 19) begin
         errors++;
         $display("FAIL lines_per_frame actual=%0d required=19", lines);
      end
      checks++;
      if (vs_cnt != 92) begin
         errors++;
         $display("FAIL vsync_count actual=%0d required=92", vs_cnt);
      end
      checks++;
      if (de_bad != 0) begin
         errors++;
         $display("FAIL de_in_vblank actual=%0d required=0", de_bad);
      end
      checks++;
      if (wraps != 2) begin
         errors++;
         $display("FAIL sy_wraps actual=%0d required=2", wraps);
      end
   endtask

   task automatic test_counter_wrap;
      int k = 0;
      do_reset(2);
      for (int i = 0; i < 257 * 42 + 50 && k < 257; i++) begin
         @(negedge clk);
         checks++;
         if (got_s !== model(cs, n_s)) begin
            errors++;
            $display("FAIL wrap_model n=%0d actual=%h required=%h", n_s, got_s, model(cs, n_s));
         end
         if (frame_s) begin
            k++;
            checks++;
            if (fc_s !== 8'(k % 256)) begin
               errors++;
               $display("FAIL frame_cnt k=%0d actual=%0d required=%0d", k, fc_s, k % 256);
            end
         end
      end
      checks++;
      if (k != 257) begin
         errors++;
         $display("FAIL wrap_timeout actual=%0d required=257", k);
      end
      checks++;
      if (fc_s !== 8'd1) begin
         errors++;
         $display("FAIL frame_cnt_final actual=%0d required=1", fc_s);
      end
   endtask

   task automatic test_small_model;
      do_reset(2);
      for (int i = 0; i < 3 * 42; i++) begin
         @(negedge clk);
         checks++;
         if (got_s !== model(cs, n_s)) begin
            errors++;
            $display("FAIL small_model n=%0d actual=%h required=%h", n_s, got_s, model(cs, n_s));
         end
      end
      repeat (4) begin
         int len = $urandom_range(3, 50);
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checks++;
            if (got_s !== model(cs, n_s)) begin
               errors++;
               $display("FAIL burst_model n=%0d actual=%h required=%h", n_s, got_s, model(cs, n_s));
            end
         end
         #($urandom_range(1, 3));
         rst_s = 1'b0;
         #1;
         checks++;
         if (got_s !== model(cs, 0)) begin
            errors++;
            $display("FAIL small_async_reset actual=%h required=%h", got_s, model(cs, 0));
         end
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst_s = 1'b1;
      end
   endtask

   task automatic test_async_mid_sync;
      int  tx = $urandom_range(18, 20);
      int  ty = $urandom_range(14, 15);
      bit  found = 1'b0;
      do_reset(1);
      for (int i = 0; i < 2 * 437 && !found; i++) begin
         @(negedge clk);
         if (int'(sx_m) == tx && int'(sy_m) == ty) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reach_target actual=none required=(%0d,%0d)", tx, ty);
      end
      checks++;
      if (hs_m !== 1'b0 || vs_m !== 1'b0) begin
         errors++;
         $display("FAIL sync_active actual=%b%b required=00", hs_m, vs_m);
      end
      #2;
      rst_m = 1'b0;
      #1;
      checks++;
      if (got_m !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL mid_sync_reset actual=%h required=%h", got_m,
                  {16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
      end
      repeat (3) @(negedge clk);
      rst_m = 1'b1;
      @(negedge clk);
      checks++;
      if (got_m !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL restart_first actual=%h required=%h", got_m,
                  {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
      end
      @(negedge clk);
      checks++;
      if (sx_m !== 16'd1 || line_m !== 1'b0) begin
         errors++;
         $display("FAIL restart_second actual sx=%0d line=%b required sx=1 line=0", sx_m, line_m);
      end
   endtask

   initial begin
      cd = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
      cm = '{16, 2, 3, 2, 12, 2, 2, 3, 1'b0, 1'b0};
      cs = '{4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1};
      rst_d = 1'b1;
      rst_m = 1'b1;
      rst_s = 1'b1;
      #1;
      rst_d = 1'b0;
      rst_m = 1'b0;
      rst_s = 1'b0;
      test_reset;
      test_line_timing;
      test_frame_timing;
      test_counter_wrap;
      test_small_model;
      test_async_mid_sync;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
